// File: rtl/iiitb_io_pkg.sv
// iiitb_io_pkg: shared encodings and defaults for the user IO output arbiter.
package iiitb_io_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int HOLD_CYCLES_DEF = 4;
   typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;
   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_MGMT = 1'b1;
endpackage

// File: rtl/iiitb_rr_arb2.sv
// iiitb_rr_arb2: combinational 2-way round-robin grant; on contention the source other than last_src wins.
module iiitb_rr_arb2
   import iiitb_io_pkg::*;
(
   input  logic cpu_v,
   input  logic mgmt_v,
   input  logic last_src,
   input  logic open,
   output logic gnt_cpu,
   output logic gnt_mgmt
);
   assign gnt_cpu = open & cpu_v & (~mgmt_v | (last_src == SRC_MGMT));
   assign gnt_mgmt = open & mgmt_v & (~cpu_v | (last_src == SRC_CPU));
endmodule

// File: rtl/iiitb_io_arbiter.sv
// iiitb_io_arbiter: round-robin scheduler sharing the user IO output bus, holding each value a minimum number of cycles.
module iiitb_io_arbiter
   import iiitb_io_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cpu_valid,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_ready,
   input  logic              mgmt_valid,
   input  logic [DATA_W-1:0] mgmt_data,
   output logic              mgmt_ready,
   input  logic              oe_en,
   output logic [DATA_W-1:0] io_out,
   output logic [DATA_W-1:0] io_oeb,
   output logic              busy,
   output logic              last_src
);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   state_e state_q;
   logic [CW-1:0] cnt_q;
   logic [DATA_W-1:0] io_out_q, io_oeb_q;
   logic last_src_q, open, gnt_cpu, gnt_mgmt;
   assign open = (state_q == ST_IDLE) | (cnt_q == '0);
   iiitb_rr_arb2 u_arb (
      .cpu_v(cpu_valid),
      .mgmt_v(mgmt_valid),
      .last_src(last_src_q),
      .open(open),
      .gnt_cpu(gnt_cpu),
      .gnt_mgmt(gnt_mgmt)
   );
   assign cpu_ready = gnt_cpu;
   assign mgmt_ready = gnt_mgmt;
   assign io_out = io_out_q;
   assign io_oeb = io_oeb_q;
   assign last_src = last_src_q;
   assign busy = (state_q == ST_HOLD) & (cnt_q != '0);
   // last_src resets to management so the core wins the first contention
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         io_out_q <= '0;
         io_oeb_q <= '1;
         last_src_q <= SRC_MGMT;
      end else begin
         io_oeb_q <= {DATA_W{~oe_en}};
         if (gnt_cpu | gnt_mgmt) begin
            io_out_q <= gnt_mgmt ? mgmt_data : cpu_data;
            last_src_q <= gnt_mgmt ? SRC_MGMT : SRC_CPU;
            cnt_q <= CW'(HOLD_CYCLES - 1);
            state_q <= ST_HOLD;
         end else if (state_q == ST_HOLD) begin
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            else state_q <= ST_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_iiitb_io_arbiter.sv
// tb_iiitb_io_arbiter: directed vectors with hand-computed expectations for the IO output arbiter.
module tb_iiitb_io_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cpu_valid = 1'b0, mgmt_valid = 1'b0, oe_en = 1'b0;
   logic [15:0] cpu_data = '0, mgmt_data = '0;
   logic cpu_ready, mgmt_ready, busy, last_src;
   logic [15:0] io_out, io_oeb;
   logic cpu_ready1, mgmt_ready1, busy1, last_src1;
   logic [15:0] io_out1, io_oeb1;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   iiitb_io_arbiter #(.DATA_W(16), .HOLD_CYCLES(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
      .mgmt_valid(mgmt_valid), .mgmt_data(mgmt_data), .mgmt_ready(mgmt_ready),
      .oe_en(oe_en), .io_out(io_out), .io_oeb(io_oeb), .busy(busy), .last_src(last_src)
   );

   iiitb_io_arbiter #(.DATA_W(16), .HOLD_CYCLES(1)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready1),
      .mgmt_valid(mgmt_valid), .mgmt_data(mgmt_data), .mgmt_ready(mgmt_ready1),
      .oe_en(oe_en), .io_out(io_out1), .io_oeb(io_oeb1), .busy(busy1), .last_src(last_src1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_io_out", io_out, 0);
      chk("rst_io_oeb", io_oeb, 16'hFFFF);
      chk("rst_last_src", last_src, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_mgmt_ready", mgmt_ready, 0);
      rst = 1'b0;
      // single core request
      cpu_valid = 1'b1;
      cpu_data = 16'h0001;
      #1;
      chk("t1_cpu_ready", cpu_ready, 1);
      chk("t1_mgmt_ready", mgmt_ready, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t1_io_out", io_out, 16'h0001);
         chk("t1_last_src", last_src, 0);
         chk("t1_busy", busy, c < 3);
         chk("t1_cpu_ready", cpu_ready, c == 3);
      end
      cpu_valid = 1'b0;
      tick();
      chk("t1_idle_io_out", io_out, 16'h0001);
      chk("t1_idle_busy", busy, 0);
      // core streams 1..16
      cpu_valid = 1'b1;
      cpu_data = 16'd1;
      for (int v = 1; v <= 16; v++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk("t2_io_out", io_out, v);
            chk("t2_cpu_ready", cpu_ready, c == 3);
            if (c == 3) begin
               cpu_data = 16'(v + 1);
               cpu_valid = v < 16;
            end
         end
      end
      tick();
      chk("t2_end_io_out", io_out, 16);
      // continuous contention from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cpu_valid = 1'b1;
      mgmt_valid = 1'b1;
      cpu_data = 16'h00A0;
      mgmt_data = 16'h0B00;
      for (int j = 0; j < 8; j++) begin
         #1;
         chk("t3_cpu_ready", cpu_ready, (j % 2) == 0);
         chk("t3_mgmt_ready", mgmt_ready, (j % 2) == 1);
         tick();
         chk("t3_io_out", io_out, (j % 2) ? 16'h0B00 + j / 2 : 16'h00A0 + j / 2);
         chk("t3_last_src", last_src, j % 2);
         if (j % 2) mgmt_data = 16'(16'h0B00 + j / 2 + 1);
         else cpu_data = 16'(16'h00A0 + j / 2 + 1);
         for (int c = 0; c < 3; c++) tick();
      end
      cpu_valid = 1'b0;
      mgmt_valid = 1'b0;
      tick();
      // HOLD_CYCLES = 1 instance takes a value every cycle
      cpu_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cpu_data = 16'(16'h0100 + i);
         #1;
         chk("t4_cpu_ready1", cpu_ready1, 1);
         chk("t4_mgmt_ready1", mgmt_ready1, 0);
         tick();
         chk("t4_io_out1", io_out1, 16'h0100 + i);
         chk("t4_busy1", busy1, 0);
      end
      chk("t4_last_src1", last_src1, 0);
      cpu_valid = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      // reset mid-hold
      oe_en = 1'b1;
      cpu_valid = 1'b1;
      cpu_data = 16'h1234;
      tick();
      cpu_valid = 1'b0;
      tick();
      chk("t5_io_out", io_out, 16'h1234);
      chk("t5_busy", busy, 1);
      chk("t5_io_oeb", io_oeb, 16'h0000);
      rst = 1'b1;
      #1;
      chk("t5_rst_io_out", io_out, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_io_oeb", io_oeb, 16'hFFFF);
      chk("t5_rst_last_src", last_src, 1);
      tick();
      rst = 1'b0;
      cpu_valid = 1'b1;
      mgmt_valid = 1'b1;
      cpu_data = 16'h5678;
      mgmt_data = 16'h9999;
      #1;
      chk("t5_cpu_ready", cpu_ready, 1);
      chk("t5_mgmt_ready", mgmt_ready, 0);
      tick();
      chk("t5_post_io_out", io_out, 16'h5678);
      chk("t5_post_last_src", last_src, 0);
      cpu_valid = 1'b0;
      mgmt_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("t5_idle_io_oeb", io_oeb, 16'h0000);
      // oe_en toggling, one-cycle lag
      oe_en = 1'b0;
      #1;
      chk("t6_lag0", io_oeb, 16'h0000);
      tick();
      chk("t6_oeb_off", io_oeb, 16'hFFFF);
      chk("t6_oeb1_off", io_oeb1, 16'hFFFF);
      oe_en = 1'b1;
      #1;
      chk("t6_lag1", io_oeb, 16'hFFFF);
      tick();
      chk("t6_oeb_on", io_oeb, 16'h0000);
      chk("t6_io_out", io_out, 16'h5678);
      oe_en = 1'b0;
      #1;
      chk("t6_lag2", io_oeb, 16'h0000);
      tick();
      chk("t6_oeb_off2", io_oeb, 16'hFFFF);
      chk("t6_io_out2", io_out, 16'h5678);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/iiitb_io_arbiter.md
# iiitb_io_arbiter

Output-port scheduler inside the user project that shares the 16-bit user IO output bus (driven onto mprj_io[23:8]) between two requesters: the RV32I core's IO store port and the management-side Wishbone write path. Arbitration is round-robin. Each accepted value is held on the pads for a programmable minimum number of cycles so that slow off-chip observers, and the chip-level bench, see every value in order. It also registers the pad output-enable.

## Interface
Parameters:
- DATA_W, 16, width of the output bus and of each request payload
- HOLD_CYCLES, 4, minimum number of cycles each accepted value stays on io_out; legal range 1..255

Ports:
- wb_clk_i  in  1  sole clock; all state updates on the rising edge
- wb_rst_i  in  1  reset, asynchronous and active-high
- cpu_valid  in  1  core has a value to drive
- cpu_data  in  DATA_W  core payload
- cpu_ready  out  1  core request accepted this cycle
- mgmt_valid  in  1  management path has a value to drive
- mgmt_data  in  DATA_W  management payload
- mgmt_ready  out  1  management request accepted this cycle
- oe_en  in  1  1 = pads driven as outputs
- io_out  out  DATA_W  registered pad data
- io_oeb  out  DATA_W  registered active-low output enable, all bits equal
- busy  out  1  a value is inside its hold window
- last_src  out  1  source of the value on io_out: 0 = core, 1 = management

## Operation
- FSM has two states:
  - IDLE: no hold is active.
  - HOLD: a hold is active; the down-counter cnt (width clog2(HOLD_CYCLES+1)) counts it out.
- Accept window (open) = state IDLE, or state HOLD with cnt == 0.
- Grant, evaluated only while the accept window is open:
  - Only one requester valid: that requester wins.
  - Both valid: the requester other than last_src wins (round-robin).
  - Neither valid: no grant.
- Readies:
  - cpu_ready = open & cpu_valid & grant_is_cpu.
  - mgmt_ready = open & mgmt_valid & grant_is_mgmt.
  - The two readies are combinational, mutually exclusive and never both high.
- On an accept at edge k:
  - io_out <= winning data, last_src <= winner, cnt <= HOLD_CYCLES-1, state <= HOLD.
- In HOLD with cnt != 0: cnt decrements by 1 per cycle; no accept is possible.
- In HOLD with cnt == 0 and no accept: state returns to IDLE; io_out keeps its value indefinitely.
- busy = (state == HOLD) & (cnt != 0).
- io_oeb <= {DATA_W{~oe_en}} every cycle, independent of the FSM.
- A requester must hold its valid and data stable until it sees ready. Dropping valid early is legal; the request is then simply not taken.

## Timing
- Reset values:
  - io_out = 0, io_oeb = all ones, last_src = 1 (so the core wins the first contention).
  - state = IDLE, cnt = 0, busy = 0.
  - Readies follow their combinational equations from IDLE.
- Latency: a request accepted at edge k appears on io_out after edge k, i.e. in cycle k+1.
- Throughput: one accept per HOLD_CYCLES cycles; the next earliest accept is edge k+HOLD_CYCLES. HOLD_CYCLES = 1 gives back-to-back accepts every cycle with cnt fixed at 0.
- A request arriving in the same cycle as cnt reaching 0 is accepted in that cycle, with no idle bubble.
- Continuous contention: grants strictly alternate between the two requesters.
- Reset asserted mid-hold: all state clears immediately (asynchronous), with no partial update. The first accept after release uses the reset value of last_src.
- io_oeb lags oe_en by exactly one cycle.

## Structure
- Shared package/header iiitb_io_pkg holds:
  - the state encodings ST_IDLE / ST_HOLD;
  - the source encodings SRC_CPU = 0 / SRC_MGMT = 1;
  - the default DATA_W and HOLD_CYCLES values.
- Sub-module iiitb_rr_arb2: purely combinational 2-way round-robin grant (inputs: two valids, last_src, open; outputs: two one-hot grants). The FSM, counter and output registers stay in the top block.

## Test plan
- Reset, then cpu_valid with data 0x0001 held; HOLD_CYCLES = 4 -> cpu_ready high for 1 cycle, io_out = 0x0001 from the next cycle, busy high for 3 cycles, last_src = 0.
- Core streams values 1..16 with valid held high -> io_out steps 1,2,...,16, each value visible for exactly 4 cycles, no gaps and no skipped values.
- Both requesters valid continuously (core 0x00A0+n, management 0x0B00+n) -> alternating grants starting with the core; 8 accepts give 4 of each in ABAB order.
- HOLD_CYCLES = 1, core valid every cycle -> cpu_ready high every cycle and io_out changes every cycle.
- Assert wb_rst_i for 1 cycle mid-hold (cnt = 2, io_out = 0x1234) -> io_out = 0, busy = 0, io_oeb = 0xFFFF immediately; the next accept lands after 1 cycle.
- Toggle oe_en 0 -> 1 -> 0 -> io_oeb goes 0xFFFF -> 0x0000 -> 0xFFFF, each change one cycle after the input, with io_out unaffected.
